// File: rtl/uop_cache_ctrl.sv
// uop_cache_ctrl: address sequencer for the loop-buffer BRAM (capture, replay with wrap, invalidate).
// Latency: BRAM controls are combinational from state/pointers/inputs; out_valid follows bram_re by 1 cycle.
// Backpressure: none; rd_req issues one read per cycle, wr_valid beyond DEPTH entries aborts via overflow.
//
// Optional feature macro: UOP_CLEAR_SWEEP_EN
//   defined   -> CLEAR sweeps NOP_WORD into every entry over DEPTH cycles
//   undefined -> CLEAR is a single cycle that only zeroes pointers and loop_len
//
// Ports:
//   clk, reset                 clock and synchronous active-high reset
//   fill_start/fill_done       open/close a loop-body capture
//   wr_valid, wr_instr         loop-body instruction to store
//   rd_req                     issue the next replayed instruction
//   abort                      discard the buffer (FILL/REPLAY only)
//   bram_we/waddr/wdata        BRAM write port
//   bram_re/raddr, bram_rdata  BRAM read port (1-cycle read latency)
//   out_instr, out_valid       replayed instruction stream
//   loop_len                   captured entry count
//   replay_active, busy        REPLAY / CLEAR indicators
//   wrap, overflow             single-cycle event pulses

module uop_cache_ctrl #(
   parameter int                DEPTH    = 8,
   parameter int                ADDR_W   = 3,
   parameter int                DATA_W   = 32,
   parameter logic [DATA_W-1:0] NOP_WORD = 'h00000013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fill_start,
   input  logic              wr_valid,
   input  logic [DATA_W-1:0] wr_instr,
   input  logic              fill_done,
   input  logic              rd_req,
   input  logic              abort,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_waddr,
   output logic [DATA_W-1:0] bram_wdata,
   output logic              bram_re,
   output logic [ADDR_W-1:0] bram_raddr,
   input  logic [DATA_W-1:0] bram_rdata,
   output logic [DATA_W-1:0] out_instr,
   output logic              out_valid,
   output logic [ADDR_W:0]   loop_len,
   output logic              replay_active,
   output logic              busy,
   output logic              wrap,
   output logic              overflow
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_REPLAY, S_CLEAR} state_t;

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [ADDR_W:0]   loop_len_q, loop_len_d;
   logic              out_valid_q;
`ifdef UOP_CLEAR_SWEEP_EN
   logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
`endif

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      loop_len_d = loop_len_q;
`ifdef UOP_CLEAR_SWEEP_EN
      clr_ptr_d  = '0;
`endif
      bram_we    = 1'b0;
      bram_waddr = '0;
      bram_wdata = '0;
      bram_re    = 1'b0;
      bram_raddr = '0;
      wrap       = 1'b0;
      overflow   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (fill_start) begin
               wr_ptr_d = '0;
               count_d  = '0;
               state_d  = S_FILL;
            end
         end
         S_FILL: begin
            if (abort) begin
               state_d = S_CLEAR;
            end else begin
               if (wr_valid) begin
                  if (count_q < DEPTH_C) begin
                     bram_we    = 1'b1;
                     bram_waddr = wr_ptr_q;
                     bram_wdata = wr_instr;
                     wr_ptr_d   = wr_ptr_q + 1'b1;
                     count_d    = count_q + ONE_C;
                  end else begin
                     overflow = 1'b1;
                     state_d  = S_CLEAR;
                  end
               end
               // count_d already includes a same-cycle write, so loop_len covers it.
               if (fill_done && !overflow) begin
                  if (count_d == '0) begin
                     state_d = S_IDLE;
                  end else begin
                     loop_len_d = count_d;
                     rd_ptr_d   = '0;
                     state_d    = S_REPLAY;
                  end
               end
            end
         end
         S_REPLAY: begin
            if (abort) begin
               state_d = S_CLEAR;
            end else if (rd_req) begin
               bram_re    = 1'b1;
               bram_raddr = rd_ptr_q;
               // Wrap on the captured length, not on DEPTH.
               if ({1'b0, rd_ptr_q} == (loop_len_q - ONE_C)) begin
                  rd_ptr_d = '0;
                  wrap     = 1'b1;
               end else begin
                  rd_ptr_d = rd_ptr_q + 1'b1;
               end
            end
         end
         S_CLEAR: begin
`ifdef UOP_CLEAR_SWEEP_EN
            bram_we    = 1'b1;
            bram_waddr = clr_ptr_q;
            bram_wdata = NOP_WORD;
            clr_ptr_d  = clr_ptr_q + 1'b1;
            if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
               wr_ptr_d   = '0;
               rd_ptr_d   = '0;
               count_d    = '0;
               loop_len_d = '0;
               state_d    = S_IDLE;
            end
`else
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            loop_len_d = '0;
            state_d    = S_IDLE;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      // While reset is held no BRAM access or event pulse may escape.
      if (reset) begin
         bram_we    = 1'b0;
         bram_waddr = '0;
         bram_wdata = '0;
         bram_re    = 1'b0;
         bram_raddr = '0;
         wrap       = 1'b0;
         overflow   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         loop_len_q  <= '0;
         out_valid_q <= 1'b0;
`ifdef UOP_CLEAR_SWEEP_EN
         clr_ptr_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         loop_len_q  <= loop_len_d;
         // An in-flight read stays valid even if abort arrives; the consumer flushes it.
         out_valid_q <= bram_re;
`ifdef UOP_CLEAR_SWEEP_EN
         clr_ptr_q   <= clr_ptr_d;
`endif
      end
   end

   assign out_instr     = bram_rdata;
   assign out_valid     = out_valid_q;
   assign loop_len      = loop_len_q;
   assign replay_active = (state_q == S_REPLAY);
   assign busy          = (state_q == S_CLEAR);

endmodule

// File: doc/uop_cache_ctrl.md
# uop_cache_ctrl

Sequencer for the loop-buffer BRAM (`uop_cache`). It owns all write and read addresses, captures a loop body during buffering, and replays it with automatic wrap-around. It invalidates the array on abort or overflow. It sits between the stream loop detector FSM, which issues start/done/abort/replay requests, and the single BRAM instance.

## Interface
Parameters:
- `DEPTH`, 8: number of instruction entries in the BRAM; power of two.
- `ADDR_W`, 3: entry index width; equals log2(DEPTH).
- `DATA_W`, 32: instruction width.
- `NOP_WORD`, 32'h00000013: invalidation pattern (RISC-V `addi x0,x0,0`).

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high; sampled on rising edge of `clk`.
- `fill_start` in 1: one-cycle pulse that begins a capture.
- `wr_valid` in 1: `wr_instr` is a loop-body instruction to store this cycle.
- `wr_instr` in DATA_W: instruction to store.
- `fill_done` in 1: one-cycle pulse that closes the capture (closing branch seen).
- `rd_req` in 1: request the next replayed instruction.
- `abort` in 1: mispredict or non-basic-block condition; discard the buffer.
- `bram_we` out 1: BRAM write enable.
- `bram_waddr` out ADDR_W: BRAM write index.
- `bram_wdata` out DATA_W: BRAM write data.
- `bram_re` out 1: BRAM read enable.
- `bram_raddr` out ADDR_W: BRAM read index.
- `bram_rdata` in DATA_W: BRAM read data, valid 1 cycle after `bram_re`.
- `out_instr` out DATA_W: replayed instruction, equal to `bram_rdata`.
- `out_valid` out 1: `out_instr` is valid this cycle.
- `loop_len` out ADDR_W+1: number of captured entries.
- `replay_active` out 1: high in REPLAY.
- `busy` out 1: high in CLEAR.
- `wrap` out 1: pulse; this read issue is the last loop entry.
- `overflow` out 1: pulse; capture exceeded DEPTH.

## Operation
- States: IDLE, FILL, REPLAY, CLEAR. `state` is registered; BRAM control outputs are combinational from state, registered pointers and inputs.
- **IDLE**
  - `fill_start` sets `wr_ptr`=0 and `count`=0, then moves to FILL.
  - All other inputs are ignored, including `abort`.
- **FILL**
  - `wr_valid` with `count`<DEPTH: `bram_we`=1, `bram_waddr`=`wr_ptr`, `bram_wdata`=`wr_instr`; `wr_ptr`++ and `count`++.
  - `wr_valid` with `count`==DEPTH: no write; `overflow` pulses; move to CLEAR.
  - `fill_done`: if `count`==0, go to IDLE. Otherwise latch `loop_len`=`count`, set `rd_ptr`=0, go to REPLAY.
  - `wr_valid` and `fill_done` in the same cycle: the write happens first, and `loop_len` includes that entry.
- **REPLAY**
  - `rd_req`: `bram_re`=1, `bram_raddr`=`rd_ptr`.
  - `rd_ptr` becomes 0 if `rd_ptr`==`loop_len`-1, else `rd_ptr`+1.
  - `wrap` is high in the same cycle as the last-entry issue.
- **CLEAR**: invalidates the array (see Configuration), then goes to IDLE with `loop_len`=0.
- **Priority**
  - `abort` in FILL or REPLAY overrides every other input that cycle: no write, no read, move to CLEAR.
  - `fill_start` outside IDLE is ignored.
- **Arithmetic**: `count` is ADDR_W+1 bits wide so it can hold DEPTH. Pointers wrap modulo `loop_len`, never modulo DEPTH.

## Timing
- Reset values:
  - `state`=IDLE.
  - All pointers, `count` and `loop_len` = 0.
  - `bram_we`, `bram_re`, `out_valid`, `wrap`, `overflow`, `busy`, `replay_active` = 0.
  - `bram_waddr`, `bram_raddr`, `bram_wdata` = 0.
- `reset` asserted mid-FILL, mid-REPLAY or mid-CLEAR returns to IDLE on the next edge. No further BRAM access occurs after that edge.
- `fill_start` at edge N puts the block in FILL at N+1. The earliest write is the cycle after `fill_start`.
- Read latency is 1: `out_valid` at N+1 is a registered copy of `bram_re` at N.
- An `abort` that arrives while a read is in flight does not suppress that read's `out_valid` on the next cycle. The consumer flushes it.
- `overflow` and `wrap` are exactly one cycle wide.
- Back-to-back `rd_req` sustains one instruction per cycle with no bubble at the wrap.

## Configuration
- `UOP_CLEAR_SWEEP_EN` defined:
  - CLEAR lasts exactly DEPTH cycles.
  - Each cycle: `bram_we`=1, `bram_waddr`=`clr_ptr` (0..DEPTH-1), `bram_wdata`=`NOP_WORD`.
  - `busy` stays high throughout.
- `UOP_CLEAR_SWEEP_EN` undefined:
  - CLEAR lasts one cycle with no BRAM write; pointers and `loop_len` are zeroed.
  - `busy` is high for that one cycle.

## Test plan
- Capture and replay: `fill_start`, then 3 writes (A,B,C), then `fill_done`. Expect `loop_len`=3 and REPLAY. Then 7 consecutive `rd_req`.
  - Required: `bram_raddr` 0,1,2,0,1,2,0.
  - Required: `out_instr` A,B,C,A,B,C,A, one cycle later.
  - Required: `wrap` on the 3rd and 6th issues.
- Overflow: DEPTH=8, 9 `wr_valid` cycles. Expect 8 writes, `overflow` pulse on the 9th, then CLEAR. With sweep enabled: 8 NOP writes at indices 0..7, then IDLE.
- Simultaneous events:
  - `wr_valid` and `fill_done` on the 2nd write: expect `loop_len`=2.
  - `abort` together with `rd_req` in REPLAY: expect `bram_re`=0 and CLEAR next cycle.
- Empty capture: `fill_start` then immediate `fill_done`. Expect return to IDLE, `loop_len`=0, no BRAM access.
- Reset mid-operation: assert `reset` during the 3rd CLEAR sweep cycle. Next cycle: IDLE, all outputs at reset values. No further `bram_we`.
- Ignored inputs: `fill_start` during REPLAY and `abort` during IDLE. Expect no state change and no BRAM activity.
